// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit for the RV32I core.
// FETCH and MEM use a request/ready handshake with a bounded wait counter.
// The instruction register is decoded into datapath selects.
// The unit traps on illegal opcodes and on bus timeouts.
// Optional feature macro: CTRL_MULDIV_EN. It adds the M-extension OP encoding
// (funct7 = 0000001) and a MULDIV wait state.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ALU_CTRL_W  = 5,
  parameter logic [31:0] RESET_IR    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  BrEq,
  input  logic                  BrLT,
  input  logic                  muldiv_done,
  output logic                  en_fetch,
  output logic                  en_fetch_data,
  output logic                  en_store_data,
  output logic                  pc_we,
  output logic                  PCSel,
  output logic                  BrUn,
  output logic                  ASel,
  output logic                  BSel,
  output logic [1:0]            WBSel,
  output logic                  isWreg,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  branch,
  output logic                  muldiv_start,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StMuldiv = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  // Last count value before the wait budget is exhausted.
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

  // IR field decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       is_load, is_store, is_opimm, is_op, is_mdiv_enc;
  logic       is_legal;
  logic       br_taken;
  logic       dec_asel, dec_bsel;
  logic [4:0] dec_alu;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  assign is_lui      = (opcode == OpLui);
  assign is_auipc    = (opcode == OpAuipc);
  assign is_jal      = (opcode == OpJal);
  assign is_jalr     = (opcode == OpJalr);
  assign is_branch   = (opcode == OpBranch);
  assign is_load     = (opcode == OpLoad);
  assign is_store    = (opcode == OpStore);
  assign is_opimm    = (opcode == OpImm);
  assign is_op       = (opcode == OpReg);
  assign is_mdiv_enc = is_op && (funct7 == 7'b0000001);

  // Legality check: funct3 010/011 is unassigned for BRANCH.
  always_comb begin
    is_legal = is_lui | is_auipc | is_jal | is_jalr | is_load | is_store | is_opimm | is_op;
    if (is_branch && (funct3[2:1] != 2'b01)) begin
      is_legal = 1'b1;
    end
`ifndef CTRL_MULDIV_EN
    if (is_mdiv_enc) begin
      is_legal = 1'b0;
    end
`endif
  end

  // funct3[2] selects a less-than compare, funct3[0] inverts the sense.
  assign br_taken = funct3[0] ^ (funct3[2] ? BrLT : BrEq);

  // PC-relative forms take the PC as operand A.
  assign dec_asel = is_auipc | is_jal | is_branch;
  assign dec_bsel = ~is_op;

  // ALU operation derived from the IR
  always_comb begin
    dec_alu = 5'b00000;
    if (is_op || (is_opimm && (funct3[1:0] == 2'b01))) begin
      dec_alu = {1'b0, ir_q[30], funct3};
    end else if (is_opimm) begin
      dec_alu = {2'b00, funct3};
    end else if (is_lui) begin
      dec_alu = 5'b10000;
    end
  end

`ifndef CTRL_MULDIV_EN
  logic unused_muldiv_done;
  assign unused_muldiv_done = muldiv_done;
`endif

  // State, IR, wait counter and sticky trap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      ir_q    <= RESET_IR;
      cnt_q   <= 8'd0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    cnt_d         = 8'd0;
    trap_d        = trap_q;
    cause_d       = cause_q;
    en_fetch      = 1'b0;
    en_fetch_data = 1'b0;
    en_store_data = 1'b0;
    pc_we         = 1'b0;
    PCSel         = 1'b0;
    BrUn          = 1'b0;
    ASel          = 1'b0;
    BSel          = 1'b0;
    WBSel         = 2'b00;
    isWreg        = 1'b0;
    alu_ctrl      = '0;
    branch        = 1'b0;
    muldiv_start  = 1'b0;

    // The ALU stays combinationally configured from EXEC through WB so the
    // address (MEM) and result/jump target (WB) remain valid.
    if ((state_q == StExec) || (state_q == StMem) || (state_q == StWb)
        || (state_q == StMuldiv)) begin
      ASel     = dec_asel;
      BSel     = dec_bsel;
      alu_ctrl = ALU_CTRL_W'(dec_alu);
    end

    unique case (state_q)
      StFetch: begin
        en_fetch = 1'b1;
        if (imem_ready) begin
          ir_d    = instruction;
          state_d = StDecode;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDecode: begin
        if (is_legal) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'd0;
        end
      end
      StExec: begin
        if (is_branch) begin
          BrUn    = funct3[1];
          PCSel   = br_taken;
          branch  = br_taken;
          pc_we   = 1'b1;
          state_d = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
`ifdef CTRL_MULDIV_EN
        end else if (is_mdiv_enc) begin
          muldiv_start = 1'b1;
          state_d      = StMuldiv;
`endif
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        en_fetch_data = is_load;
        en_store_data = ~is_load;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWb: begin
        isWreg = (ir_q[11:7] != 5'd0);
        pc_we  = 1'b1;
        PCSel  = is_jal | is_jalr;
        if (is_load) begin
          WBSel = 2'b00;
        end else if (is_jal || is_jalr) begin
          WBSel = 2'b10;
`ifdef CTRL_MULDIV_EN
        end else if (is_mdiv_enc) begin
          WBSel = 2'b11;
`endif
        end else begin
          WBSel = 2'b01;
        end
        state_d = StFetch;
      end
`ifdef CTRL_MULDIV_EN
      StMuldiv: begin
        if (muldiv_done) begin
          state_d = StWb;
        end
      end
`endif
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset masks every request and strobe in the cycle it is sampled.
    if (rst) begin
      en_fetch      = 1'b0;
      en_fetch_data = 1'b0;
      en_store_data = 1'b0;
      pc_we         = 1'b0;
      PCSel         = 1'b0;
      BrUn          = 1'b0;
      ASel          = 1'b0;
      BSel          = 1'b0;
      WBSel         = 2'b00;
      isWreg        = 1'b0;
      alu_ctrl      = '0;
      branch        = 1'b0;
      muldiv_start  = 1'b0;
    end
  end

  assign rs1        = rst ? 5'd0 : ir_q[19:15];
  assign rs2        = rst ? 5'd0 : ir_q[24:20];
  assign rd         = rst ? 5'd0 : ir_q[11:7];
  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? 2'd0 : cause_q;
  assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (default parameters, MEM_TIMEOUT = 16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        imem_ready, dmem_ready, BrEq, BrLT, muldiv_done;
  logic        en_fetch, en_fetch_data, en_store_data, pc_we, PCSel, BrUn, ASel, BSel;
  logic [1:0]  WBSel;
  logic        isWreg;
  logic [4:0]  alu_ctrl;
  logic [4:0]  rs1, rs2, rd;
  logic        branch, muldiv_start, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_ADDI0 = {12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011};
  localparam logic [31:0] I_BEQ   = {7'd0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011};
  localparam logic [31:0] I_BNE   = {7'd0, 5'd2, 5'd1, 3'b001, 5'b01000, 7'b1100011};
  localparam logic [31:0] I_BLTU  = {7'd0, 5'd2, 5'd1, 3'b110, 5'b01000, 7'b1100011};
  localparam logic [31:0] I_LW    = {12'd4, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] I_SW    = {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011};
  localparam logic [31:0] I_JAL   = {1'b0, 10'b0000001000, 1'b0, 8'd0, 5'd1, 7'b1101111};
  localparam logic [31:0] I_MUL   = 32'h0220_81B3;
  localparam logic [31:0] I_ILL   = 32'h0000_007F;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .BrEq         (BrEq),
    .BrLT         (BrLT),
    .muldiv_done  (muldiv_done),
    .en_fetch     (en_fetch),
    .en_fetch_data(en_fetch_data),
    .en_store_data(en_store_data),
    .pc_we        (pc_we),
    .PCSel        (PCSel),
    .BrUn         (BrUn),
    .ASel         (ASel),
    .BSel         (BSel),
    .WBSel        (WBSel),
    .isWreg       (isWreg),
    .alu_ctrl     (alu_ctrl),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .branch       (branch),
    .muldiv_start (muldiv_start),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state        (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Fetch one instruction with zero wait states and advance into DECODE.
  task automatic fetch(input logic [31:0] instr);
    instruction = instr;
    imem_ready  = 1'b1;
    nxt();
    imem_ready  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instruction = 32'd0; imem_ready = 1'b1; dmem_ready = 1'b0;
    BrEq = 1'b0; BrLT = 1'b0; muldiv_done = 1'b0;

    // Reset: outputs masked even with imem_ready high
    smp();
    chk("rst_en_fetch", en_fetch, 0);
    chk("rst_state", state, 0);
    chk("rst_trap", trap, 0);
    chk("rst_pc_we", pc_we, 0);
    nxt();
    smp();
    chk("rst_rd", rd, 0);
    chk("rst_isWreg", isWreg, 0);
    nxt();
    rst = 1'b0; imem_ready = 1'b0;

    // ADDI x1,x0,5: states 0,1,2,4 then fetch
    instruction = I_ADDI; imem_ready = 1'b1;
    smp(); chk("addi_f_state", state, 0); chk("addi_f_en", en_fetch, 1);
    nxt(); imem_ready = 1'b0;
    smp(); chk("addi_d_state", state, 1); chk("addi_d_rd", rd, 1); chk("addi_d_en", en_fetch, 0);
    nxt();
    smp(); chk("addi_e_state", state, 2); chk("addi_e_bsel", BSel, 1);
    chk("addi_e_alu", alu_ctrl, 0); chk("addi_e_pcwe", pc_we, 0);
    nxt();
    smp(); chk("addi_w_state", state, 4); chk("addi_w_wreg", isWreg, 1);
    chk("addi_w_wbsel", WBSel, 1); chk("addi_w_bsel", BSel, 1);
    chk("addi_w_pcwe", pc_we, 1); chk("addi_w_pcsel", PCSel, 0);
    nxt();

    // BEQ taken (BrEq=1)
    instruction = I_BEQ; imem_ready = 1'b1; BrEq = 1'b1;
    smp(); chk("addi_next_fetch", state, 0); chk("beq_f_en", en_fetch, 1);
    nxt(); imem_ready = 1'b0;
    smp(); chk("beq_d_branch", branch, 0); chk("beq_d_state", state, 1);
    nxt();
    smp(); chk("beq_e_state", state, 2); chk("beq_e_branch", branch, 1);
    chk("beq_e_pcsel", PCSel, 1); chk("beq_e_pcwe", pc_we, 1);
    chk("beq_e_brun", BrUn, 0); chk("beq_e_asel", ASel, 1);
    nxt();

    // BNE not taken (BrEq=1)
    instruction = I_BNE; imem_ready = 1'b1;
    smp(); chk("beq_next_fetch", state, 0);
    nxt(); imem_ready = 1'b0;
    nxt();
    smp(); chk("bne_e_state", state, 2); chk("bne_e_branch", branch, 0);
    chk("bne_e_pcsel", PCSel, 0); chk("bne_e_pcwe", pc_we, 1);
    nxt();

    // BLTU taken via BrLT with unsigned compare
    BrEq = 1'b0; BrLT = 1'b1; instruction = I_BLTU; imem_ready = 1'b1;
    smp(); chk("bne_next_fetch", state, 0);
    nxt(); imem_ready = 1'b0;
    nxt();
    smp(); chk("bltu_e_branch", branch, 1); chk("bltu_e_brun", BrUn, 1);
    chk("bltu_e_pcsel", PCSel, 1);
    nxt();
    BrLT = 1'b0;

    // LW with three wait states: 8 cycles total
    instruction = I_LW; imem_ready = 1'b1;
    smp(); chk("lw_f_state", state, 0);
    nxt(); imem_ready = 1'b0;
    nxt();
    smp(); chk("lw_e_state", state, 2); chk("lw_e_rdreq", en_fetch_data, 0);
    chk("lw_e_bsel", BSel, 1);
    nxt();
    for (int i = 0; i < 3; i++) begin
      smp(); chk("lw_m_wait_state", state, 3); chk("lw_m_wait_req", en_fetch_data, 1);
      chk("lw_m_wait_pcwe", pc_we, 0);
      nxt();
    end
    dmem_ready = 1'b1;
    smp(); chk("lw_m_ready_req", en_fetch_data, 1); chk("lw_m_ready_state", state, 3);
    nxt(); dmem_ready = 1'b0;
    smp(); chk("lw_w_state", state, 4); chk("lw_w_wbsel", WBSel, 0);
    chk("lw_w_wreg", isWreg, 1); chk("lw_w_req", en_fetch_data, 0); chk("lw_w_pcwe", pc_we, 1);
    nxt();

    // SW with zero wait states: 4 cycles
    instruction = I_SW; imem_ready = 1'b1;
    smp(); chk("lw_next_fetch", state, 0);
    nxt(); imem_ready = 1'b0;
    nxt(); nxt();
    dmem_ready = 1'b1;
    smp(); chk("sw_m_state", state, 3); chk("sw_m_wrreq", en_store_data, 1);
    chk("sw_m_pcwe", pc_we, 1); chk("sw_m_wreg", isWreg, 0);
    nxt(); dmem_ready = 1'b0;

    // JAL x1: WB writes PC+4 and redirects the PC
    instruction = I_JAL; imem_ready = 1'b1;
    smp(); chk("sw_next_fetch", state, 0);
    nxt(); imem_ready = 1'b0;
    nxt();
    smp(); chk("jal_e_asel", ASel, 1); chk("jal_e_bsel", BSel, 1);
    nxt();
    smp(); chk("jal_w_state", state, 4); chk("jal_w_wbsel", WBSel, 2);
    chk("jal_w_pcsel", PCSel, 1); chk("jal_w_wreg", isWreg, 1);
    nxt();

    // ADDI x0,x0,1: no register write
    fetch(I_ADDI0);
    nxt(); nxt();
    smp(); chk("addi0_w_state", state, 4); chk("addi0_w_wreg", isWreg, 0);
    chk("addi0_w_pcwe", pc_we, 1);
    nxt();

    // MUL x3,x1,x2
    fetch(I_MUL);
    nxt();
`ifdef CTRL_MULDIV_EN
    smp(); chk("mul_e_state", state, 2); chk("mul_e_start", muldiv_start, 1);
    chk("mul_e_bsel", BSel, 0);
    nxt();
    smp(); chk("mul_md_state", state, 5); chk("mul_md_start", muldiv_start, 0);
    nxt();
    muldiv_done = 1'b1;
    smp(); chk("mul_md_done_state", state, 5);
    nxt(); muldiv_done = 1'b0;
    smp(); chk("mul_w_wbsel", WBSel, 3); chk("mul_w_wreg", isWreg, 1);
    nxt();
`else
    smp(); chk("mul_trap_state", state, 6); chk("mul_trap", trap, 1);
    chk("mul_trap_cause", trap_cause, 0); chk("mul_start", muldiv_start, 0);
    nxt();
`endif
    rst = 1'b1; nxt(); rst = 1'b0;

    // Illegal opcode traps from DECODE and stays there
    fetch(I_ILL);
    nxt();
    smp(); chk("ill_state", state, 6); chk("ill_trap", trap, 1);
    chk("ill_cause", trap_cause, 0); chk("ill_en_fetch", en_fetch, 0);
    nxt(); nxt();
    smp(); chk("ill_sticky_state", state, 6); chk("ill_sticky_pcwe", pc_we, 0);
    rst = 1'b1;
    smp(); chk("ill_rst_trap", trap, 0); chk("ill_rst_state", state, 0);
    nxt(); rst = 1'b0;

    // Fetch timeout after 16 wait cycles
    for (int i = 0; i < 16; i++) begin
      smp(); chk("fto_wait_en", en_fetch, 1); chk("fto_wait_state", state, 0);
      nxt();
    end
    smp(); chk("fto_state", state, 6); chk("fto_trap", trap, 1);
    chk("fto_cause", trap_cause, 1); chk("fto_en", en_fetch, 0);
    nxt();
    smp(); chk("fto_sticky", trap, 1);
    rst = 1'b1;
    smp(); chk("fto_rst_trap", trap, 0); chk("fto_rst_en", en_fetch, 0);
    nxt(); rst = 1'b0;
    smp(); chk("fto_resume_en", en_fetch, 1); chk("fto_resume_state", state, 0);

    // Ready on the last allowed wait cycle wins over the timeout
    for (int i = 0; i < 15; i++) nxt();
    instruction = I_ADDI; imem_ready = 1'b1;
    smp(); chk("edge_fetch_state", state, 0); chk("edge_fetch_en", en_fetch, 1);
    nxt(); imem_ready = 1'b0;
    smp(); chk("edge_decode_state", state, 1); chk("edge_no_trap", trap, 0);
    nxt(); nxt(); nxt();

    // Data timeout on a load
    fetch(I_LW);
    nxt(); nxt();
    for (int i = 0; i < 16; i++) begin
      smp(); chk("dto_wait_state", state, 3); chk("dto_wait_req", en_fetch_data, 1);
      nxt();
    end
    smp(); chk("dto_state", state, 6); chk("dto_cause", trap_cause, 2);
    chk("dto_trap", trap, 1); chk("dto_req", en_fetch_data, 0);
    rst = 1'b1; nxt(); rst = 1'b0;

    // Reset during an outstanding load aborts the request
    fetch(I_LW);
    nxt(); nxt(); nxt();
    smp(); chk("abort_pre_req", en_fetch_data, 1);
    rst = 1'b1;
    smp(); chk("abort_req", en_fetch_data, 0); chk("abort_state", state, 0);
    nxt(); rst = 1'b0;
    smp(); chk("abort_resume_en", en_fetch, 1); chk("abort_resume_state", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
